// File: rtl/inst_d_if.sv
// Decode-stage bus: fetch input, flush, writeback port, hazard back to
// fetch, and the ID/EX pipeline register contents toward execute.
//   master : fetch / writeback / control side (drives instruction, pc4,
//            flush, wb_*; observes hazard and ex_*)
//   slave  : the decode stage itself
interface inst_d_if #(
  parameter int unsigned XLEN = 32
);
  logic [31:0]     instruction;
  logic [XLEN-1:0] pc4;
  logic            flush;
  logic            wb_en;
  logic [4:0]      wb_addr;
  logic [XLEN-1:0] wb_data;
  logic            hazard;
  logic            ex_valid;
  logic [XLEN-1:0] ex_pc4;
  logic [XLEN-1:0] ex_rs_data;
  logic [XLEN-1:0] ex_rt_data;
  logic [XLEN-1:0] ex_imm;
  logic [4:0]      ex_rs;
  logic [4:0]      ex_rt;
  logic [4:0]      ex_rd;
  logic [5:0]      ex_opcode;
  logic [5:0]      ex_funct;
  logic [4:0]      ex_dest;
  logic            ex_reg_write;
  logic            ex_mem_read;

  modport master (
    output instruction, pc4, flush, wb_en, wb_addr, wb_data,
    input  hazard, ex_valid, ex_pc4, ex_rs_data, ex_rt_data, ex_imm,
           ex_rs, ex_rt, ex_rd, ex_opcode, ex_funct, ex_dest,
           ex_reg_write, ex_mem_read
  );

  modport slave (
    input  instruction, pc4, flush, wb_en, wb_addr, wb_data,
    output hazard, ex_valid, ex_pc4, ex_rs_data, ex_rt_data, ex_imm,
           ex_rs, ex_rt, ex_rd, ex_opcode, ex_funct, ex_dest,
           ex_reg_write, ex_mem_read
  );
endinterface

// File: rtl/inst_d.sv
// Instruction decode stage: IF/ID register, register file with writeback
// bypass, field/immediate decode, ID/EX register and load-use hazard.
//   clk  : clock, all state on posedge
//   rst  : asynchronous active-low reset
//   bus  : inst_d_if.slave (fetch in, writeback in, hazard out, ID/EX out)
module inst_d #(
  parameter int unsigned NREG = 32,
  parameter int unsigned XLEN = 32
) (
  input logic     clk,
  input logic     rst,
  inst_d_if.slave bus
);
  localparam int unsigned AW    = $clog2(NREG);
  localparam int unsigned IMMW  = 16;
  localparam logic [5:0]  OP_R  = 6'b000000;
  localparam logic [5:0]  OP_LW = 6'b100011;
  localparam logic [5:0]  OP_SW = 6'b101011;
  localparam logic [5:0]  OP_BEQ = 6'b000100;
  localparam logic [5:0]  OP_BNE = 6'b000101;

  // IF/ID pipeline register
  logic            r_ifid_valid;
  logic [31:0]     r_ifid_instr;
  logic [XLEN-1:0] r_ifid_pc4;

  // ID/EX pipeline register
  logic            r_ex_valid;
  logic [XLEN-1:0] r_ex_pc4;
  logic [XLEN-1:0] r_ex_rs_data;
  logic [XLEN-1:0] r_ex_rt_data;
  logic [XLEN-1:0] r_ex_imm;
  logic [4:0]      r_ex_rs;
  logic [4:0]      r_ex_rt;
  logic [4:0]      r_ex_rd;
  logic [5:0]      r_ex_opcode;
  logic [5:0]      r_ex_funct;
  logic [4:0]      r_ex_dest;
  logic            r_ex_reg_write;
  logic            r_ex_mem_read;

  logic [XLEN-1:0] r_regs [NREG];

  // Decode of the IF/ID instruction
  logic [5:0]      w_opcode;
  logic [4:0]      w_rs;
  logic [4:0]      w_rt;
  logic [4:0]      w_rd;
  logic [5:0]      w_funct;
  logic [IMMW-1:0] w_imm16;
  logic            w_rtype;
  logic            w_zext;
  logic [XLEN-1:0] w_imm;
  logic [4:0]      w_dest;
  logic            w_reg_write;
  logic            w_mem_read;
  logic            w_uses_rt;
  logic [XLEN-1:0] w_rs_data;
  logic [XLEN-1:0] w_rt_data;
  logic            w_hazard;
  logic            w_bubble;

  assign w_opcode = r_ifid_instr[31:26];
  assign w_rs     = r_ifid_instr[25:21];
  assign w_rt     = r_ifid_instr[20:16];
  assign w_rd     = r_ifid_instr[15:11];
  assign w_funct  = r_ifid_instr[5:0];
  assign w_imm16  = r_ifid_instr[15:0];

  assign w_rtype  = (w_opcode == OP_R);
  // andi / ori / xori take an unsigned immediate
  assign w_zext   = (w_opcode == 6'b001100) || (w_opcode == 6'b001101) ||
                    (w_opcode == 6'b001110);
  assign w_imm    = w_zext ? {{(XLEN-IMMW){1'b0}}, w_imm16}
                           : {{(XLEN-IMMW){w_imm16[IMMW-1]}}, w_imm16};
  assign w_dest   = w_rtype ? w_rd : w_rt;
  assign w_mem_read  = (w_opcode == OP_LW);
  assign w_reg_write = (w_rtype || (w_opcode[5:3] == 3'b001) || w_mem_read) &&
                       (w_dest != 5'd0);
  assign w_uses_rt   = w_rtype || (w_opcode == OP_SW) ||
                       (w_opcode == OP_BEQ) || (w_opcode == OP_BNE);

  // Register read with same-cycle writeback bypass; r0 always reads zero
  always_comb begin
    w_rs_data = r_regs[AW'(w_rs)];
    w_rt_data = r_regs[AW'(w_rt)];
    if (bus.wb_en && (bus.wb_addr == w_rs)) w_rs_data = bus.wb_data;
    if (bus.wb_en && (bus.wb_addr == w_rt)) w_rt_data = bus.wb_data;
    if (w_rs == 5'd0) w_rs_data = '0;
    if (w_rt == 5'd0) w_rt_data = '0;
  end

  // Load in EX whose result the IF/ID instruction needs: stall one cycle
  assign w_hazard = r_ex_valid && r_ex_mem_read && r_ifid_valid &&
                    (r_ex_dest != 5'd0) &&
                    ((r_ex_dest == w_rs) || (w_uses_rt && (r_ex_dest == w_rt)));
  assign w_bubble = bus.flush || w_hazard || !r_ifid_valid;

  // IF/ID: flush kills, hazard holds, otherwise capture
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ifid_valid <= 1'b0;
      r_ifid_instr <= '0;
      r_ifid_pc4   <= '0;
    end else if (bus.flush) begin
      r_ifid_valid <= 1'b0;
      r_ifid_instr <= '0;
      r_ifid_pc4   <= '0;
    end else if (!w_hazard) begin
      r_ifid_valid <= 1'b1;
      r_ifid_instr <= bus.instruction;
      r_ifid_pc4   <= bus.pc4;
    end
  end

  // ID/EX: bubble on flush, stall or empty IF/ID
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ex_valid     <= 1'b0;
      r_ex_pc4       <= '0;
      r_ex_rs_data   <= '0;
      r_ex_rt_data   <= '0;
      r_ex_imm       <= '0;
      r_ex_rs        <= '0;
      r_ex_rt        <= '0;
      r_ex_rd        <= '0;
      r_ex_opcode    <= '0;
      r_ex_funct     <= '0;
      r_ex_dest      <= '0;
      r_ex_reg_write <= 1'b0;
      r_ex_mem_read  <= 1'b0;
    end else if (w_bubble) begin
      r_ex_valid     <= 1'b0;
      r_ex_pc4       <= '0;
      r_ex_rs_data   <= '0;
      r_ex_rt_data   <= '0;
      r_ex_imm       <= '0;
      r_ex_rs        <= '0;
      r_ex_rt        <= '0;
      r_ex_rd        <= '0;
      r_ex_opcode    <= '0;
      r_ex_funct     <= '0;
      r_ex_dest      <= '0;
      r_ex_reg_write <= 1'b0;
      r_ex_mem_read  <= 1'b0;
    end else begin
      r_ex_valid     <= 1'b1;
      r_ex_pc4       <= r_ifid_pc4;
      r_ex_rs_data   <= w_rs_data;
      r_ex_rt_data   <= w_rt_data;
      r_ex_imm       <= w_imm;
      r_ex_rs        <= w_rs;
      r_ex_rt        <= w_rt;
      r_ex_rd        <= w_rd;
      r_ex_opcode    <= w_opcode;
      r_ex_funct     <= w_funct;
      r_ex_dest      <= w_dest;
      r_ex_reg_write <= w_reg_write;
      r_ex_mem_read  <= w_mem_read;
    end
  end

  // Register file write port; r0 is never written
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < int'(NREG); i++) r_regs[i] <= '0;
    end else if (bus.wb_en && (bus.wb_addr != 5'd0)) begin
      r_regs[AW'(bus.wb_addr)] <= bus.wb_data;
    end
  end

  assign bus.hazard       = w_hazard;
  assign bus.ex_valid     = r_ex_valid;
  assign bus.ex_pc4       = r_ex_pc4;
  assign bus.ex_rs_data   = r_ex_rs_data;
  assign bus.ex_rt_data   = r_ex_rt_data;
  assign bus.ex_imm       = r_ex_imm;
  assign bus.ex_rs        = r_ex_rs;
  assign bus.ex_rt        = r_ex_rt;
  assign bus.ex_rd        = r_ex_rd;
  assign bus.ex_opcode    = r_ex_opcode;
  assign bus.ex_funct     = r_ex_funct;
  assign bus.ex_dest      = r_ex_dest;
  assign bus.ex_reg_write = r_ex_reg_write;
  assign bus.ex_mem_read  = r_ex_mem_read;
endmodule

// File: tb/tb_inst_d.sv
// Directed testbench for the inst_d decode stage.
module tb_inst_d;
  logic clk;
  logic rst;
  int   errors;
  int   checks;

  inst_d_if #(.XLEN(32)) bus ();

  inst_d #(.NREG(32), .XLEN(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic present(input logic [31:0] ins, input logic [31:0] p4);
    bus.instruction = ins;
    bus.pc4         = p4;
  endtask

  task automatic drain();
    present(32'h0, 32'h0);
    step();
    step();
  endtask

  task automatic test_reset();
    present(32'h2009_0003, 32'h40);
    step();
    present(32'h8C22_0000, 32'h44);
    step();
    checks++; if (bus.ex_valid !== 1'b1) begin errors++; $display("FAIL rst_pre_valid got=%b exp=1", bus.ex_valid); end
    rst = 1'b0;
    #1;
    checks++; if (bus.ex_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got=%b exp=0", bus.ex_valid); end
    checks++; if (bus.ex_pc4 !== 32'h0) begin errors++; $display("FAIL rst_pc4 got=%h exp=0", bus.ex_pc4); end
    checks++; if (bus.ex_imm !== 32'h0) begin errors++; $display("FAIL rst_imm got=%h exp=0", bus.ex_imm); end
    checks++; if (bus.ex_dest !== 5'd0) begin errors++; $display("FAIL rst_dest got=%0d exp=0", bus.ex_dest); end
    checks++; if (bus.hazard !== 1'b0) begin errors++; $display("FAIL rst_hazard got=%b exp=0", bus.hazard); end
    @(negedge clk);
    rst = 1'b1;
    present(32'h2001_0005, 32'h4);
    step();
    checks++; if (bus.ex_valid !== 1'b0) begin errors++; $display("FAIL lat_one_edge got=%b exp=0", bus.ex_valid); end
    present(32'h0, 32'h8);
    step();
    checks++; if (bus.ex_valid !== 1'b1) begin errors++; $display("FAIL addi_valid got=%b exp=1", bus.ex_valid); end
    checks++; if (bus.ex_imm !== 32'h5) begin errors++; $display("FAIL addi_imm got=%h exp=5", bus.ex_imm); end
    checks++; if (bus.ex_dest !== 5'd1) begin errors++; $display("FAIL addi_dest got=%0d exp=1", bus.ex_dest); end
    checks++; if (bus.ex_reg_write !== 1'b1) begin errors++; $display("FAIL addi_rw got=%b exp=1", bus.ex_reg_write); end
    checks++; if (bus.ex_pc4 !== 32'h4) begin errors++; $display("FAIL addi_pc4 got=%h exp=4", bus.ex_pc4); end
    checks++; if (bus.ex_opcode !== 6'b001000) begin errors++; $display("FAIL addi_op got=%b exp=001000", bus.ex_opcode); end
    drain();
  endtask

  task automatic test_imm();
    present(32'h2002_FFFF, 32'h10);
    step();
    present(32'h3402_FFFF, 32'h14);
    step();
    checks++; if (bus.ex_imm !== 32'hFFFF_FFFF) begin errors++; $display("FAIL imm_sext got=%h exp=ffffffff", bus.ex_imm); end
    present(32'h3C02_8000, 32'h18);
    step();
    checks++; if (bus.ex_imm !== 32'h0000_FFFF) begin errors++; $display("FAIL imm_zext got=%h exp=0000ffff", bus.ex_imm); end
    checks++; if (bus.ex_dest !== 5'd2) begin errors++; $display("FAIL ori_dest got=%0d exp=2", bus.ex_dest); end
    present(32'h0, 32'h1C);
    step();
    checks++; if (bus.ex_imm !== 32'hFFFF_8000) begin errors++; $display("FAIL lui_sext got=%h exp=ffff8000", bus.ex_imm); end
    checks++; if (bus.ex_reg_write !== 1'b1) begin errors++; $display("FAIL lui_rw got=%b exp=1", bus.ex_reg_write); end
    drain();
  endtask

  task automatic test_load_use();
    // lw r2 ; add r3,r2,r4 : rs match
    present(32'h8C22_0000, 32'h20);
    step();
    present(32'h0044_1820, 32'h24);
    step();
    checks++; if (bus.ex_mem_read !== 1'b1) begin errors++; $display("FAIL lw_memrd got=%b exp=1", bus.ex_mem_read); end
    checks++; if (bus.hazard !== 1'b1) begin errors++; $display("FAIL lu_add_hz got=%b exp=1", bus.hazard); end
    present(32'h0, 32'h28);
    step();
    checks++; if (bus.hazard !== 1'b0) begin errors++; $display("FAIL lu_add_hz_clear got=%b exp=0", bus.hazard); end
    checks++; if (bus.ex_valid !== 1'b0) begin errors++; $display("FAIL lu_add_bubble got=%b exp=0", bus.ex_valid); end
    step();
    checks++; if (bus.ex_valid !== 1'b1) begin errors++; $display("FAIL lu_add_valid got=%b exp=1", bus.ex_valid); end
    checks++; if (bus.ex_dest !== 5'd3) begin errors++; $display("FAIL lu_add_dest got=%0d exp=3", bus.ex_dest); end
    checks++; if (bus.ex_funct !== 6'h20) begin errors++; $display("FAIL lu_add_funct got=%h exp=20", bus.ex_funct); end
    checks++; if (bus.ex_pc4 !== 32'h24) begin errors++; $display("FAIL lu_add_pc4 got=%h exp=24", bus.ex_pc4); end
    drain();
    // lw r2 ; addi r3,r2,1
    present(32'h8C22_0000, 32'h30);
    step();
    present(32'h2043_0001, 32'h34);
    step();
    checks++; if (bus.hazard !== 1'b1) begin errors++; $display("FAIL lu_addi_hz got=%b exp=1", bus.hazard); end
    present(32'h0, 32'h38);
    step();
    checks++; if (bus.ex_valid !== 1'b0) begin errors++; $display("FAIL lu_addi_bubble got=%b exp=0", bus.ex_valid); end
    step();
    checks++; if (bus.ex_rs !== 5'd2) begin errors++; $display("FAIL lu_addi_rs got=%0d exp=2", bus.ex_rs); end
    drain();
    // lw r0 ; addi r3,r0,1 : no stall
    present(32'h8C20_0000, 32'h40);
    step();
    present(32'h2003_0001, 32'h44);
    step();
    checks++; if (bus.hazard !== 1'b0) begin errors++; $display("FAIL lu_r0_hz got=%b exp=0", bus.hazard); end
    checks++; if (bus.ex_reg_write !== 1'b0) begin errors++; $display("FAIL lw_r0_rw got=%b exp=0", bus.ex_reg_write); end
    present(32'h0, 32'h48);
    step();
    checks++; if (bus.ex_dest !== 5'd3) begin errors++; $display("FAIL lu_r0_next got=%0d exp=3", bus.ex_dest); end
    drain();
    // lw r2 ; addi r2,r5,1 : rt not a source, no stall
    present(32'h8C22_0000, 32'h50);
    step();
    present(32'h20A2_0001, 32'h54);
    step();
    checks++; if (bus.hazard !== 1'b0) begin errors++; $display("FAIL lu_addi_rt_hz got=%b exp=0", bus.hazard); end
    drain();
    // lw r2 ; sw r2,0(r5) : store reads rt, stall
    present(32'h8C22_0000, 32'h60);
    step();
    present(32'hACA2_0000, 32'h64);
    step();
    checks++; if (bus.hazard !== 1'b1) begin errors++; $display("FAIL lu_sw_hz got=%b exp=1", bus.hazard); end
    present(32'h0, 32'h68);
    step();
    step();
    checks++; if (bus.ex_reg_write !== 1'b0) begin errors++; $display("FAIL sw_rw got=%b exp=0", bus.ex_reg_write); end
    checks++; if (bus.ex_valid !== 1'b1) begin errors++; $display("FAIL sw_valid got=%b exp=1", bus.ex_valid); end
    drain();
  endtask

  task automatic test_flush_priority();
    present(32'h8C22_0000, 32'h70);
    step();
    present(32'h0044_1820, 32'h74);
    step();
    checks++; if (bus.hazard !== 1'b1) begin errors++; $display("FAIL fl_pre_hz got=%b exp=1", bus.hazard); end
    bus.flush = 1'b1;
    present(32'h2006_0009, 32'h0C);
    step();
    bus.flush = 1'b0;
    checks++; if (bus.ex_valid !== 1'b0) begin errors++; $display("FAIL fl_ex_valid got=%b exp=0", bus.ex_valid); end
    checks++; if (bus.hazard !== 1'b0) begin errors++; $display("FAIL fl_hazard got=%b exp=0", bus.hazard); end
    present(32'h2005_0007, 32'h100);
    step();
    checks++; if (bus.ex_valid !== 1'b0) begin errors++; $display("FAIL fl_ifid_empty got=%b exp=0", bus.ex_valid); end
    present(32'h0, 32'h104);
    step();
    checks++; if (bus.ex_valid !== 1'b1) begin errors++; $display("FAIL fl_next_valid got=%b exp=1", bus.ex_valid); end
    checks++; if (bus.ex_pc4 !== 32'h100) begin errors++; $display("FAIL fl_next_pc4 got=%h exp=100", bus.ex_pc4); end
    checks++; if (bus.ex_imm !== 32'h7) begin errors++; $display("FAIL fl_next_imm got=%h exp=7", bus.ex_imm); end
    checks++; if (bus.ex_dest !== 5'd5) begin errors++; $display("FAIL fl_next_dest got=%0d exp=5", bus.ex_dest); end
    drain();
  endtask

  task automatic test_writeback();
    // add r6,r4,r0 decoded while r4 is being written
    present(32'h0080_3020, 32'h200);
    step();
    bus.wb_en = 1'b1; bus.wb_addr = 5'd4; bus.wb_data = 32'hDEAD_BEEF;
    present(32'h0, 32'h204);
    step();
    bus.wb_en = 1'b0;
    checks++; if (bus.ex_rs_data !== 32'hDEAD_BEEF) begin errors++; $display("FAIL byp_rs got=%h exp=deadbeef", bus.ex_rs_data); end
    checks++; if (bus.ex_rt_data !== 32'h0) begin errors++; $display("FAIL byp_rt_r0 got=%h exp=0", bus.ex_rt_data); end
    // add r7,r4,r4 reads the stored value
    present(32'h0084_3820, 32'h208);
    step();
    present(32'h0, 32'h20C);
    step();
    checks++; if (bus.ex_rs_data !== 32'hDEAD_BEEF) begin errors++; $display("FAIL rf_rs got=%h exp=deadbeef", bus.ex_rs_data); end
    checks++; if (bus.ex_rt_data !== 32'hDEAD_BEEF) begin errors++; $display("FAIL rf_rt got=%h exp=deadbeef", bus.ex_rt_data); end
    // add r8,r0,r0 while writing r0
    present(32'h0000_4020, 32'h210);
    step();
    bus.wb_en = 1'b1; bus.wb_addr = 5'd0; bus.wb_data = 32'h0000_1234;
    present(32'h0, 32'h214);
    step();
    bus.wb_en = 1'b0;
    checks++; if (bus.ex_rs_data !== 32'h0) begin errors++; $display("FAIL r0_byp_rs got=%h exp=0", bus.ex_rs_data); end
    checks++; if (bus.ex_rt_data !== 32'h0) begin errors++; $display("FAIL r0_byp_rt got=%h exp=0", bus.ex_rt_data); end
    present(32'h0000_4020, 32'h218);
    step();
    present(32'h0, 32'h21C);
    step();
    checks++; if (bus.ex_rs_data !== 32'h0) begin errors++; $display("FAIL r0_read got=%h exp=0", bus.ex_rs_data); end
    checks++; if (bus.ex_dest !== 5'd8) begin errors++; $display("FAIL r0_dest got=%0d exp=8", bus.ex_dest); end
    drain();
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst = 1'b0;
    bus.instruction = '0;
    bus.pc4 = '0;
    bus.flush = 1'b0;
    bus.wb_en = 1'b0;
    bus.wb_addr = '0;
    bus.wb_data = '0;
    step();
    step();
    @(negedge clk);
    rst = 1'b1;
    test_reset();
    test_imm();
    test_load_use();
    test_flush_priority();
    test_writeback();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
